// File: rtl/exec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// exec_ctrl_pkg
// Request/response records and controller state encoding shared between the
// execute controller, the execute datapath and the neighbouring stages.
// EX_XLEN / EX_ILEN fix the record field widths (data path / PC width).
// ---------------------------------------------------------------------------
package exec_ctrl_pkg;

  localparam int EX_XLEN = 32;
  localparam int EX_ILEN = 32;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [2:0]         func3;
    logic [6:0]         func7;
    logic [EX_XLEN-1:0] valA;
    logic [EX_XLEN-1:0] valB;
    logic [EX_XLEN-1:0] valC;
    logic [EX_ILEN-1:0] pc;
  } ex_req_t;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [2:0]         func3;
    logic [EX_XLEN-1:0] valE;
    logic [EX_XLEN-1:0] valB;
    logic [EX_ILEN-1:0] link;
    logic [EX_ILEN-1:0] pc;
  } ex_rsp_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HALT     = 2'd2
  } ex_state_t;

endpackage

// File: rtl/opcodes_pkg.sv
// ---------------------------------------------------------------------------
// opcodes_pkg
// Base-ISA major opcode constants (instruction bits [6:0]) shared by the
// decode, execute and memory stages.
// ---------------------------------------------------------------------------
package opcodes_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

endpackage

// File: rtl/execute_controller.sv
// ---------------------------------------------------------------------------
// execute_controller
// One-entry holding stage in front of the combinational execute datapath.
// Accepts a decoded request, presents it to the datapath on dp_req, forwards
// the result to the memory stage, redirects fetch for taken control
// transfers and halts on an illegal instruction until halt_clear.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_req request from decode
//   dp_req                   held request to the execute datapath
//   dp_valE/dp_cond/dp_fault datapath result, branch condition, illegal flag
//   out_valid/out_ready/out_rsp  result to the memory stage
//   redirect_valid/redirect_pc   one-cycle fetch redirect
//   fault/fault_pc           halted on illegal instruction, its PC
//   halt_clear               leave the halted state
//   retired_count/stall_count    only with EXEC_CTRL_PERF_EN defined
//
// Configuration macro: EXEC_CTRL_PERF_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module execute_controller
  import opcodes_pkg::*;
  import exec_ctrl_pkg::*;
#(
  parameter int XLEN = EX_XLEN,
  parameter int ILEN = EX_ILEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  ex_req_t         in_req,
  output ex_req_t         dp_req,
  input  logic [XLEN-1:0] dp_valE,
  input  logic            dp_cond,
  input  logic            dp_fault,
  output logic            out_valid,
  input  logic            out_ready,
  output ex_rsp_t         out_rsp,
  output logic            redirect_valid,
  output logic [ILEN-1:0] redirect_pc,
  output logic            fault,
  output logic [ILEN-1:0] fault_pc,
  input  logic            halt_clear
`ifdef EXEC_CTRL_PERF_EN
  ,
  output logic [31:0]     retired_count,
  output logic [31:0]     stall_count
`endif
);

  ex_state_t          state;
  logic               held_valid;
  ex_req_t            held;

  logic               is_jal;
  logic               is_jalr;
  logic               ctrl_xfer;
  logic               out_fire;
  logic [EX_ILEN-1:0] link;
  logic [ILEN-1:0]    redir_tgt;

  assign dp_req = held;

  assign is_jal    = (held.opcode == OPC_JAL);
  assign is_jalr   = (held.opcode == OPC_JALR);
  assign ctrl_xfer = is_jal || is_jalr || ((held.opcode == OPC_BRANCH) && dp_cond);

  assign out_valid = (state == ST_RUN) && held_valid && !dp_fault;
  assign out_fire  = out_valid && out_ready;

  // A firing control transfer cannot hand over its slot: the instructions
  // behind it are on the wrong path until the redirect has gone out.
  assign in_ready = (state == ST_RUN) && (!held_valid || (out_fire && !ctrl_xfer));

  assign link = held.pc + EX_ILEN'(4);

  always_comb begin
    out_rsp        = '0;
    out_rsp.opcode = held.opcode;
    out_rsp.func3  = held.func3;
    out_rsp.valB   = held.valB;
    out_rsp.link   = link;
    out_rsp.pc     = held.pc;
    out_rsp.valE   = (is_jal || is_jalr) ? EX_XLEN'(link) : EX_XLEN'(dp_valE);
  end

  // JALR targets are forced to even addresses.
  always_comb begin
    redir_tgt = ILEN'(dp_valE);
    if (is_jalr) redir_tgt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_RUN;
      held_valid     <= 1'b0;
      held           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      fault          <= 1'b0;
      fault_pc       <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (held_valid && dp_fault) begin
            held_valid <= 1'b0;
            fault      <= 1'b1;
            fault_pc   <= ILEN'(held.pc);
            state      <= ST_HALT;
          end else if (out_fire && ctrl_xfer) begin
            held_valid     <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= redir_tgt;
            state          <= ST_REDIRECT;
          end else if (in_valid && in_ready) begin
            held       <= in_req;
            held_valid <= 1'b1;
          end else if (out_fire) begin
            held_valid <= 1'b0;
          end
        end
        ST_REDIRECT: begin
          redirect_valid <= 1'b0;
          state          <= ST_RUN;
        end
        ST_HALT: begin
          if (halt_clear) begin
            fault <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef EXEC_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count <= '0;
      stall_count   <= '0;
    end else begin
      if (out_fire)               retired_count <= retired_count + 32'd1;
      if (out_valid && !out_ready) stall_count  <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/execute_controller.md
EXECUTE_CONTROLLER -- requirements
Module: execute_controller

Interface
REQ-001 Parameter XLEN, default 32, data path width.
REQ-002 Parameter ILEN, default 32, instruction/PC width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  upstream (decode) holds a request.
REQ-006 in_ready  output  1  controller accepts request this cycle.
REQ-007 in_req  input  ex_req_t  opcode[6:0], func3[2:0], func7[6:0], valA, valB, valC (XLEN), pc (ILEN).
REQ-008 dp_req  output  ex_req_t  held request driven to the combinational execute datapath.
REQ-009 dp_valE  input  XLEN  datapath result.
REQ-010 dp_cond  input  1  datapath branch condition.
REQ-011 dp_fault  input  1  datapath illegal-instruction flag.
REQ-012 out_valid  output  1  result ready for memory stage.
REQ-013 out_ready  input  1  memory stage accepts result.
REQ-014 out_rsp  output  ex_rsp_t  opcode, func3, valE, valB (store data), link (pc+4), pc.
REQ-015 redirect_valid  output  1  one-cycle fetch redirect pulse.
REQ-016 redirect_pc  output  ILEN  redirect target.
REQ-017 fault  output  1  controller halted on illegal instruction.
REQ-018 fault_pc  output  ILEN  PC of faulting instruction.
REQ-019 halt_clear  input  1  releases HALT.

Function
REQ-020 Controller SHALL hold one entry (held_valid + held request); accept when in_valid && in_ready; held request drives dp_req the following cycle.
REQ-021 States SHALL be RUN, REDIRECT, HALT; in_ready SHALL be 0 outside RUN.
REQ-022 In RUN, in_ready SHALL be 1 when !held_valid, or when the held entry fires (out_valid && out_ready) and is not a control transfer.
REQ-023 out_valid SHALL equal held_valid && !dp_fault in RUN; out_rsp SHALL be valid combinationally from held entry and dp_valE; accept-to-out_valid latency is 1 cycle.
REQ-024 out_rsp.valE SHALL be dp_valE, except JAL/JALR where it SHALL be pc+4 (link = pc+4 always, modulo 2^ILEN).
REQ-025 A held entry SHALL stay stable on dp_req/out_rsp while out_valid && !out_ready.
REQ-026 Control transfer = JAL, JALR, or BRANCH with dp_cond=1; on its firing, RUN->REDIRECT, held_valid cleared.
REQ-027 In REDIRECT (exactly one cycle) redirect_valid=1, redirect_pc = registered dp_valE (JALR: bit 0 cleared); then REDIRECT->RUN.
REQ-028 Not-taken BRANCH SHALL fire as a normal entry with no redirect.
REQ-029 held_valid && dp_fault in RUN SHALL drop the entry (no out_valid), RUN->HALT, fault=1, fault_pc=held pc.
REQ-030 In HALT, halt_clear=1 SHALL return to RUN next cycle with fault=0; halt_clear in other states SHALL be ignored.
REQ-031 redirect_valid SHALL never coincide with out_valid.

Reset
REQ-032 rst SHALL immediately force RUN, held_valid=0, in_ready=1, out_valid=0, redirect_valid=0, redirect_pc=0, fault=0, fault_pc=0, dp_req=0.
REQ-033 Reset asserted mid-stall, mid-REDIRECT or in HALT SHALL discard the held entry with no output or redirect.

Configuration
REQ-034 With EXEC_CTRL_PERF_EN defined, SHALL add outputs retired_count[31:0] (+1 per out fire) and stall_count[31:0] (+1 per cycle out_valid && !out_ready), wrapping at 2^32, reset to 0.
REQ-035 Without EXEC_CTRL_PERF_EN, those ports and counters SHALL not exist.

Structure
REQ-036 ex_req_t, ex_rsp_t and the state enum SHALL live in a shared package exec_ctrl_pkg; opcode constants come from the existing opcodes package.
REQ-037 No sub-module; the execute datapath is instantiated by the parent, not inside this block.

Verification
REQ-038 Back-to-back ADDs, out_ready=1: one result per cycle, first out_valid 1 cycle after accept, valE=valA+valB.
REQ-039 out_ready=0 for 3 cycles on held ADD: out_rsp stable, in_ready=0, stall_count=3 (PERF_EN).
REQ-040 BEQ pc=0x100, valC=0x20, valA=valB=5: next cycle redirect_valid=1, redirect_pc=0x120, in_ready=0 for that cycle.
REQ-041 JALR valA=0x201, valC=0: out valE=pc+4, redirect_pc=0x200.
REQ-042 Illegal opcode at pc=0x40: no out_valid, fault=1, fault_pc=0x40, in_ready=0 until halt_clear, then RUN.
REQ-043 rst asserted in REDIRECT cycle: redirect_valid drops immediately, all outputs at reset values.
